// File: rtl/hpm_counter_bank.sv
// Hardware performance monitor counter bank (mhpmcounter3.. / mhpmevent3..).
//
// Counters 3..NUM_COUNTERS+2 each select one event source through their mhpmevent
// register and add that source's per-cycle count, taken from a one-cycle event stage.
// Overflow (carry out of bit CNT_WIDTH-1) sets mhpmevent[63] (OF) and raises a
// one-cycle registered interrupt request when OF was previously clear.
//
// Optional feature: define HPM_PRIV_FILTER_EN to store mhpmevent bits 62:60 and
// suppress counting in M/S/U mode respectively. Without it those bits read zero and
// the privilege level is ignored.
//
// Ports:
//   clk_i               clock
//   rst_i               synchronous active-high reset
//   addr_i              CSR address
//   we_i                CSR write enable
//   data_i / data_o     CSR write / read data (read is combinational)
//   mcountinhibit_i     bit i freezes counter i
//   priv_lvl_i          current privilege level (M=3, S=1, U=0)
//   events_i            event e count in slice [e*INC_WIDTH-1 -: INC_WIDTH]
//   count_ovf_int_req_o one-cycle overflow interrupt request
//   mhpm_ovf_bits_o     per-counter OF bits
module hpm_counter_bank #(
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned NUM_COUNTERS   = 29,
  parameter int unsigned NUM_EVENTS     = 28,
  parameter int unsigned CNT_WIDTH      = 64,
  parameter int unsigned INC_WIDTH      = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CSR_ADDR_WIDTH-1:0]        addr_i,
  input  logic                             we_i,
  input  logic [XLEN-1:0]                  data_i,
  output logic [XLEN-1:0]                  data_o,
  input  logic [31:0]                      mcountinhibit_i,
  input  logic [1:0]                       priv_lvl_i,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0]  events_i,
  output logic                             count_ovf_int_req_o,
  output logic [NUM_COUNTERS+2:3]          mhpm_ovf_bits_o
);

  localparam int unsigned NC = NUM_COUNTERS;
  localparam logic [CSR_ADDR_WIDTH-1:0] CntBase = CSR_ADDR_WIDTH'(12'hB03);
  localparam logic [CSR_ADDR_WIDTH-1:0] EvtBase = CSR_ADDR_WIDTH'(12'h323);

  // Elaboration-time parameter checks
  if (XLEN != 64) begin : gen_xlen_chk
    $error("hpm_counter_bank: XLEN must be 64");
  end
  if (NUM_COUNTERS < 1 || NUM_COUNTERS > 29) begin : gen_nc_chk
    $error("hpm_counter_bank: NUM_COUNTERS must be 1..29");
  end
  if (CNT_WIDTH < 32 || CNT_WIDTH > 64) begin : gen_cw_chk
    $error("hpm_counter_bank: CNT_WIDTH must be 32..64");
  end

  logic [NUM_EVENTS*INC_WIDTH-1:0] ev_q;
  logic [CNT_WIDTH-1:0]            cnt_q [NC];
  logic [CNT_WIDTH-1:0]            cnt_d [NC];
  logic [55:0]                     sel_q [NC];
  logic [55:0]                     sel_d [NC];
  logic [2:0]                      filt_q [NC];
  logic [NC-1:0]                   of_q, of_d;
  logic                            ovf_int_q, ovf_int_d;

  logic [NC-1:0]                   cnt_we, evt_we, count_en, of_set, filtered;
  logic [INC_WIDTH-1:0]            inc [NC];
  logic [CNT_WIDTH:0]              sum [NC];

  // CSR write decode
  always_comb begin
    for (int unsigned k = 0; k < NC; k++) begin
      cnt_we[k] = we_i && (addr_i == CntBase + CSR_ADDR_WIDTH'(k));
      evt_we[k] = we_i && (addr_i == EvtBase + CSR_ADDR_WIDTH'(k));
    end
  end

`ifdef HPM_PRIV_FILTER_EN
  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivS = 2'b01;
  localparam logic [1:0] PrivM = 2'b11;

  // filt_q[k] = mhpmevent bits {62 (M), 61 (S), 60 (U)}
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NC; k++) filt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (evt_we[k]) filt_q[k] <= data_i[62:60];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NC; k++) begin
      filtered[k] = ((priv_lvl_i == PrivM) && filt_q[k][2]) ||
                    ((priv_lvl_i == PrivS) && filt_q[k][1]) ||
                    ((priv_lvl_i == PrivU) && filt_q[k][0]);
    end
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < NC; k++) filt_q[k] = '0;
    filtered = '0;
  end

  logic unused_priv;
  assign unused_priv = ^priv_lvl_i;
`endif

  // Bits 59:56 are not stored; low inhibit bits have no counter.
  logic unused_bits;
  assign unused_bits = ^{data_i, mcountinhibit_i};

  // Event select, increment and next-state
  always_comb begin
    ovf_int_d = 1'b0;
    for (int unsigned k = 0; k < NC; k++) begin
      logic hit;
      hit    = 1'b0;
      inc[k] = '0;
      for (int unsigned e = 1; e <= NUM_EVENTS; e++) begin
        if (sel_q[k] == 56'(e)) begin
          hit    = 1'b1;
          inc[k] = ev_q[e*INC_WIDTH-1 -: INC_WIDTH];
        end
      end
      count_en[k] = hit && !mcountinhibit_i[k+3] && !filtered[k];
      sum[k]      = {1'b0, cnt_q[k]} + (CNT_WIDTH+1)'(inc[k]);

      cnt_d[k]  = cnt_q[k];
      sel_d[k]  = sel_q[k];
      of_d[k]   = of_q[k];
      of_set[k] = 1'b0;
      // Software writes win; the hardware increment for that index is dropped.
      if (cnt_we[k]) begin
        cnt_d[k] = data_i[CNT_WIDTH-1:0];
      end else if (evt_we[k]) begin
        sel_d[k] = data_i[55:0];
        of_d[k]  = data_i[63];
      end else if (count_en[k]) begin
        cnt_d[k] = sum[k][CNT_WIDTH-1:0];
        if (sum[k][CNT_WIDTH] && !of_q[k]) begin
          of_d[k]   = 1'b1;
          of_set[k] = 1'b1;
        end
      end
    end
    ovf_int_d = |of_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_q      <= '0;
      of_q      <= '0;
      ovf_int_q <= 1'b0;
      for (int unsigned k = 0; k < NC; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
      end
    end else begin
      ev_q      <= events_i;
      of_q      <= of_d;
      ovf_int_q <= ovf_int_d;
      for (int unsigned k = 0; k < NC; k++) begin
        cnt_q[k] <= cnt_d[k];
        sel_q[k] <= sel_d[k];
      end
    end
  end

  // CSR read mux; unimplemented and unmapped addresses read zero.
  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < NC; k++) begin
      if (addr_i == CntBase + CSR_ADDR_WIDTH'(k)) begin
        data_o = XLEN'(cnt_q[k]);
      end
      if (addr_i == EvtBase + CSR_ADDR_WIDTH'(k)) begin
        data_o = XLEN'({of_q[k], filt_q[k], 4'b0000, sel_q[k]});
      end
    end
  end

  assign count_ovf_int_req_o = ovf_int_q;
  assign mhpm_ovf_bits_o     = of_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank, built with NUM_COUNTERS=4 and CNT_WIDTH=48.
module tb_hpm_counter_bank;

  localparam int unsigned NumCnt = 4;
  localparam int unsigned NumEv  = 28;
  localparam int unsigned IncW   = 2;
  localparam int unsigned CntW   = 48;

`ifdef HPM_PRIV_FILTER_EN
  localparam bit FiltEn = 1'b1;
`else
  localparam bit FiltEn = 1'b0;
`endif

  localparam logic [11:0] Cnt3 = 12'hB03;
  localparam logic [11:0] Cnt4 = 12'hB04;
  localparam logic [11:0] Cnt5 = 12'hB05;
  localparam logic [11:0] Cnt6 = 12'hB06;
  localparam logic [11:0] Evt3 = 12'h323;
  localparam logic [11:0] Evt4 = 12'h324;
  localparam logic [11:0] Evt5 = 12'h325;
  localparam logic [11:0] Evt6 = 12'h326;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [11:0]            addr;
  logic                   we;
  logic [63:0]            wdata;
  logic [63:0]            rdata;
  logic [31:0]            inhibit;
  logic [1:0]             priv;
  logic [NumEv*IncW-1:0]  ev;
  logic                   irq;
  logic [NumCnt+2:3]      ovf;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hpm_counter_bank #(
    .CSR_ADDR_WIDTH (12),
    .XLEN           (64),
    .NUM_COUNTERS   (NumCnt),
    .NUM_EVENTS     (NumEv),
    .CNT_WIDTH      (CntW),
    .INC_WIDTH      (IncW)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .addr_i              (addr),
    .we_i                (we),
    .data_i              (wdata),
    .data_o              (rdata),
    .mcountinhibit_i     (inhibit),
    .priv_lvl_i          (priv),
    .events_i            (ev),
    .count_ovf_int_req_o (irq),
    .mhpm_ovf_bits_o     (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a, input logic [63:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; addr = '0; we = 1'b0; wdata = '0; inhibit = '0; priv = 2'b11; ev = '0;
    tick();
    tick();
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_irq", 64'(irq), 64'd0);
    check("post_rst_ovf", 64'(ovf), 64'd0);
    check_csr("post_rst_cnt3", Cnt3, 64'd0);

    // Event 1 at 2 per cycle for 10 cycles into counter3
    csr_wr(Evt3, 64'd1);
    check_csr("evt3_rd", Evt3, 64'd1);
    ev[1:0] = 2'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) check_csr("cnt3_lat1", Cnt3, 64'd0);
      if (c == 2) check_csr("cnt3_lat2", Cnt3, 64'd2);
    end
    ev = '0;
    tick();
    check_csr("cnt3_sum", Cnt3, 64'd20);
    tick();
    check_csr("cnt3_hold", Cnt3, 64'd20);

    // 48-bit wrap on counter4
    csr_wr(Evt4, 64'd1);
    csr_wr(Cnt4, 64'h0000_FFFF_FFFF_FFFF);
    check_csr("cnt4_wr", Cnt4, 64'h0000_FFFF_FFFF_FFFF);
    ev[1:0] = 2'd1;
    tick();
    ev = '0;
    check("irq_pre", 64'(irq), 64'd0);
    tick();
    check_csr("cnt4_wrap", Cnt4, 64'd0);
    check("of4_set", 64'(ovf), 64'b0010);
    check("irq_pulse", 64'(irq), 64'd1);
    tick();
    check("irq_one_cycle", 64'(irq), 64'd0);
    // Upper write bits dropped; second wrap with OF already set is silent
    csr_wr(Cnt4, 64'hABCD_FFFF_FFFF_FFFF);
    check_csr("cnt4_trunc", Cnt4, 64'h0000_FFFF_FFFF_FFFF);
    ev[1:0] = 2'd1;
    tick();
    ev = '0;
    tick();
    check_csr("cnt4_wrap2", Cnt4, 64'd0);
    check("irq_nopulse", 64'(irq), 64'd0);
    tick();
    check("irq_nopulse2", 64'(irq), 64'd0);
    check("of4_kept", 64'(ovf), 64'b0010);
    check_csr("cnt3_total", Cnt3, 64'd22);

    // Software write beats a same-cycle increment on counter5
    csr_wr(Evt5, 64'd2);
    ev[3:2] = 2'd3;
    tick();
    ev = '0;
    tick();
    check_csr("cnt5_inc", Cnt5, 64'd3);
    ev[3:2] = 2'd3;
    tick();
    ev = '0;
    csr_wr(Cnt5, 64'h100);
    check_csr("cnt5_swprio", Cnt5, 64'h100);
    tick();
    check_csr("cnt5_after", Cnt5, 64'h100);

    // mhpmevent storage: bits 59:56 never stored, 62:60 only with filtering
    csr_wr(Evt6, 64'hFF00_0000_0000_0003);
    check_csr("evt6_rd", Evt6, FiltEn ? 64'hF000_0000_0000_0003 : 64'h8000_0000_0000_0003);
    check("of6_sw", 64'(ovf), 64'b1010);

    // Privilege filter: U-mode suppressed (bit 60), M-mode counts
    csr_wr(Evt6, 64'h1000_0000_0000_0002);
    csr_wr(Cnt6, 64'd0);
    check("of6_clr", 64'(ovf), 64'b0010);
    check_csr("evt6_rd2", Evt6, FiltEn ? 64'h1000_0000_0000_0002 : 64'h2);
    priv = 2'b00;
    ev[3:2] = 2'd1;
    repeat (5) tick();
    ev = '0;
    tick();
    tick();
    check_csr("cnt6_u", Cnt6, FiltEn ? 64'd0 : 64'd5);
    priv = 2'b11;
    ev[3:2] = 2'd1;
    repeat (5) tick();
    ev = '0;
    tick();
    tick();
    check_csr("cnt6_m", Cnt6, FiltEn ? 64'd5 : 64'd10);

    // Unimplemented / unmapped addresses
    csr_wr(12'hB0A, 64'hABCD);
    check_csr("cnt10_rd", 12'hB0A, 64'd0);
    csr_wr(12'h32A, 64'h5);
    check_csr("evt10_rd", 12'h32A, 64'd0);
    check_csr("cnt7_rd", 12'hB07, 64'd0);

    // mcountinhibit freezes counter3, clearing it resumes
    csr_wr(Cnt3, 64'h55);
    inhibit[3] = 1'b1;
    ev[1:0] = 2'd3;
    repeat (4) tick();
    ev = '0;
    tick();
    tick();
    check_csr("cnt3_inhibit", Cnt3, 64'h55);
    inhibit[3] = 1'b0;
    ev[1:0] = 2'd1;
    tick();
    ev = '0;
    tick();
    check_csr("cnt3_resume", Cnt3, 64'h56);

    // Reset mid-count with OF set; same-cycle write must be ignored
    ev[1:0] = 2'd2;
    tick();
    tick();
    check("of_before_rst", 64'(ovf), 64'b0010);
    rst   = 1'b1;
    addr  = Cnt3;
    wdata = 64'h77;
    we    = 1'b1;
    tick();
    rst = 1'b0;
    we  = 1'b0;
    check("rst2_ovf", 64'(ovf), 64'd0);
    check("rst2_irq", 64'(irq), 64'd0);
    check_csr("rst2_cnt3", Cnt3, 64'd0);
    check_csr("rst2_cnt4", Cnt4, 64'd0);
    check_csr("rst2_cnt5", Cnt5, 64'd0);
    check_csr("rst2_evt3", Evt3, 64'd0);
    tick();
    check_csr("rst2_cnt3_next", Cnt3, 64'd0);
    check("rst2_irq_next", 64'(irq), 64'd0);
    ev = '0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
